vregs_wb_sched: RTL and testbench

Write-back scheduler for the vector register file. Three producers compete for the file's single write port: the vector ALU (0), the vector load unit (1) and the vector move/broadcast unit (2). The block arbitrates among them round-robin and registers the winning write onto the port. It also keeps a 16-bit pending-write scoreboard, so the issue stage can reserve destinations and check source registers for hazards. It sits between the execution units and the register file; its wEn/wAddr/wLen/wData outputs connect directly to the file's write port.

---
 rtl/vregs_wb_sched.sv | 84 ++++++++
 tb/tb_vregs_wb_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vregs_wb_sched.sv
// rtl/vregs_wb_sched.sv - round-robin write-back scheduler with pending-write scoreboard
module vregs_wb_sched #(
    parameter int NREQ = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         res_valid,
    input  logic [3:0]   res_addr,
    output logic         res_ready,
    input  logic [3:0]   q_addr0,
    input  logic [3:0]   q_addr1,
    output logic         q_busy0,
    output logic         q_busy1,
    input  logic [2:0]   req_valid,
    input  logic [11:0]  req_addr,
    input  logic [11:0]  req_len,
    input  logic [767:0] req_data,
    output logic [2:0]   req_ready,
    output logic         wEn,
    output logic [3:0]   wAddr,
    output logic [3:0]   wLen,
    output logic [255:0] wData,
    output logic [15:0]  busy
);

    logic [1:0]  ptr;
    logic [1:0]  ptrNext;
    logic [2:0]  grant;
    logic [1:0]  gIdx;
    logic        anyGrant;
    logic [15:0] busyNext;
    int          idx;

    // Scan ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
    always_comb begin
        grant = '0;
        gIdx  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (grant == 3'b000 && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gIdx       = 2'(idx);
            end
        end
    end

    assign anyGrant  = |grant;
    assign req_ready = grant;
    assign ptrNext   = (gIdx == 2'd2) ? 2'd0 : gIdx + 2'd1;

    assign res_ready = res_valid & ~busy[res_addr];
    assign q_busy0   = busy[q_addr0];
    assign q_busy1   = busy[q_addr1];

    // Commit clear first, then reservation set: an accepted reservation always sticks.
    always_comb begin
        busyNext = busy;
        if (wEn) busyNext[wAddr] = 1'b0;
        if (res_ready) busyNext[res_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= 2'd0;
            wEn   <= 1'b0;
            wAddr <= 4'd0;
            wLen  <= 4'd0;
            wData <= '0;
            busy  <= 16'h0000;
        end else begin
            busy <= busyNext;
            wEn  <= anyGrant;
            if (anyGrant) begin
                ptr   <= ptrNext;
                wAddr <= req_addr[4*gIdx +: 4];
                wLen  <= req_len[4*gIdx +: 4];
                wData <= req_data[256*gIdx +: 256];
            end
        end
    end

endmodule

// File: tb/tb_vregs_wb_sched.sv
// tb/tb_vregs_wb_sched.sv - scoreboard bench for vregs_wb_sched
module tb_vregs_wb_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         res_valid;
    logic [3:0]   res_addr;
    logic         res_ready;
    logic [3:0]   q_addr0, q_addr1;
    logic         q_busy0, q_busy1;
    logic [2:0]   req_valid;
    logic [11:0]  req_addr, req_len;
    logic [767:0] req_data;
    logic [2:0]   req_ready;
    logic         wEn;
    logic [3:0]   wAddr, wLen;
    logic [255:0] wData;
    logic [15:0]  busy;

    always #5 clk = ~clk;

    vregs_wb_sched #(.NREQ(3)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_addr(res_addr), .res_ready(res_ready),
        .q_addr0(q_addr0), .q_addr1(q_addr1), .q_busy0(q_busy0), .q_busy1(q_busy1),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
        .req_ready(req_ready),
        .wEn(wEn), .wAddr(wAddr), .wLen(wLen), .wData(wData), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]   a;
        logic [3:0]   l;
        logic [255:0] d;
    } wr_t;

    int           total = 0;
    int           bad = 0;
    wr_t          expQ[$];
    wr_t          monE;
    int           mPtr = 0;
    logic [15:0]  mBusy = 16'h0;
    bit           mPend = 0;
    logic [3:0]   mPendAddr = 4'd0;
    logic [255:0] lastData [16];
    logic [255:0] dX, dY;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected grant.
    always @(negedge clk) begin
        if (wEn === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h want no write", wAddr);
            end else begin
                monE = expQ.pop_front();
                chk("wAddr", wAddr, monE.a);
                chk("wLen", wLen, monE.l);
                chk("wData", wData, monE.d);
            end
            lastData[wAddr] = wData;
        end
    end

    task automatic idle();
        rst = 0; res_valid = 0; res_addr = 0; q_addr0 = 0; q_addr1 = 0;
        req_valid = 0; req_addr = 0; req_len = 0; req_data = '0;
    endtask

    task automatic setReq(input int i, input logic [3:0] a, input logic [3:0] l, input logic [255:0] d);
        req_valid[i] = 1'b1;
        req_addr[4*i +: 4] = a;
        req_len[4*i +: 4] = l;
        req_data[256*i +: 256] = d;
    endtask

    // One cycle: check combinational outputs against the model, then advance the model past the edge.
    task automatic tick();
        int   g;
        int   i;
        bit   resOk;
        wr_t  e;
        logic [2:0] expRdy;
        #2;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            i = (mPtr + k) % 3;
            if (g < 0 && req_valid[i]) g = i;
        end
        expRdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        resOk = res_valid && !mBusy[res_addr];
        chk("req_ready", req_ready, expRdy);
        chk("busy", busy, mBusy);
        chk("wEn", wEn, mPend);
        chk("res_ready", res_ready, resOk);
        chk("q_busy0", q_busy0, mBusy[q_addr0]);
        chk("q_busy1", q_busy1, mBusy[q_addr1]);
        if (!rst && g >= 0) begin
            e.a = req_addr[4*g +: 4];
            e.l = req_len[4*g +: 4];
            e.d = req_data[256*g +: 256];
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mBusy = 16'h0; mPtr = 0; mPend = 0;
        end else begin
            if (mPend) mBusy[mPendAddr] = 1'b0;
            if (resOk) mBusy[res_addr] = 1'b1;
            mPend = (g >= 0);
            if (g >= 0) begin
                mPendAddr = req_addr[4*g +: 4];
                mPtr = (g + 1) % 3;
            end
        end
    endtask

    task automatic rstTick();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // single request from unit 1
        tick();
        setReq(1, 4'd5, 4'd8, {32{8'hA5}});
        tick();
        chk("t1_wEn", wEn, 1'b1);
        chk("t1_wAddr", wAddr, 4'd5);
        chk("t1_wLen", wLen, 4'd8);
        chk("t1_wData", wData, {32{8'hA5}});
        idle(); tick();

        // all three held valid: rotating grants, back-to-back writes
        rstTick();
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < 3; r++) setReq(r, 4'(c + r), 4'(r), {8{$urandom}});
            tick();
        end
        idle(); tick();

        // reservation, rejected duplicate, clear two cycles after grant
        res_valid = 1; res_addr = 3; tick();
        q_addr0 = 3; tick();
        chk("t3_qbusy", q_busy0, 1'b1);
        idle(); setReq(1, 4'd3, 4'd1, {8{$urandom}}); tick();
        idle(); tick();
        chk("t3_clear", busy[3], 1'b0);
        res_valid = 1; res_addr = 3; #1;
        chk("t3_rereserve", res_ready, 1'b1);
        tick();

        // set and clear on different registers in one cycle
        idle(); res_valid = 1; res_addr = 2; tick();
        idle(); setReq(0, 4'd2, 4'd4, {8{$urandom}}); tick();
        idle(); res_valid = 1; res_addr = 7; tick();
        chk("t4_set7", busy[7], 1'b1);
        chk("t4_clr2", busy[2], 1'b0);
        idle(); tick();

        // grant in the reset cycle is discarded
        rstTick();
        idle(); rst = 1; setReq(2, 4'd6, 4'd2, {8{$urandom}}); tick();
        idle(); tick();
        chk("t5_wEn", wEn, 1'b0);
        chk("t5_busy", busy, 16'h0);
        for (int r = 0; r < 3; r++) setReq(r, 4'd1, 4'd1, {8{$urandom}});
        #1;
        chk("t5_ptr0", req_ready, 3'b001);
        tick();
        idle(); tick();

        // same destination from two units commits in grant order
        rstTick();
        dX = {8{$urandom}};
        dY = {8{$urandom}};
        setReq(0, 4'd9, 4'd3, dX);
        setReq(2, 4'd9, 4'd3, dY);
        tick();
        req_valid[0] = 1'b0;
        tick();
        idle(); tick(); tick();
        chk("t6_order", lastData[9], dY);

        // randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            res_valid = $urandom_range(0, 1);
            res_addr = 4'($urandom);
            q_addr0 = 4'($urandom);
            q_addr1 = 4'($urandom);
            for (int r = 0; r < 3; r++)
                if ($urandom_range(0, 2) != 0) setReq(r, 4'($urandom), 4'($urandom), {8{$urandom}});
            tick();
        end

        idle();
        repeat (3) tick();
        chk("queue_drained", 256'(expQ.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
